// File: rtl/mm_sequencer.sv
// mm_sequencer: matrix-multiply controller.
// Decodes 32-bit operations offered over a valid/ready handshake and drives the W/X
// register-file controls (page selects, row write strobes, shift enable, line switch
// pulses, y write-back strobes) plus busy/done/err status.
// Opcodes: 0 no-op, 1 multiply, 2 serial write, 3 config, 4..15 illegal.
// Ports:
//   i_clk, i_reset (sync, active high), i_enable (global stall)
//   i_op_valid / o_op_ready / i_operation : command handshake
//   i_in_data, i_mult_valid               : serial write data, multiplier row valids
//   o_busy, o_done, o_err                 : status
//   o_shift_en, o_w_switch, o_x_switch    : multiplier feed controls
//   o_w_rd_page, o_x_rd_page, o_w_wr_page, o_x_wr_page : page selects
//   o_w_we, o_x_we, o_wr_data, o_y_valid  : write strobes, write data, y write-back
module mm_sequencer #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ARRAY_N        = 8,
   parameter int unsigned PAGE_BITS      = 2,
   parameter int unsigned CELL_W         = 6,
   parameter int unsigned LINE_W         = 3,
   parameter int unsigned DRAIN_LAT      = 17,
   parameter int unsigned DEF_W_CELLS_M1 = 15,
   parameter int unsigned DEF_W_LINES_M1 = 1,
   parameter int unsigned DEF_X_LINES_M1 = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_op_valid,
   output logic                 o_op_ready,
   input  logic [31:0]          i_operation,
   input  logic [DATA_W-1:0]    i_in_data,
   input  logic [ARRAY_N-1:0]   i_mult_valid,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err,
   output logic                 o_shift_en,
   output logic                 o_w_switch,
   output logic                 o_x_switch,
   output logic [PAGE_BITS-1:0] o_w_rd_page,
   output logic [PAGE_BITS-1:0] o_x_rd_page,
   output logic [PAGE_BITS-1:0] o_w_wr_page,
   output logic [PAGE_BITS-1:0] o_x_wr_page,
   output logic [ARRAY_N-1:0]   o_w_we,
   output logic [ARRAY_N-1:0]   o_x_we,
   output logic [DATA_W-1:0]    o_wr_data,
   output logic [ARRAY_N-1:0]   o_y_valid
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam int unsigned DRAIN_W = $clog2(DRAIN_LAT + 1);

   state_e               r_state, w_state_nxt;
   logic [CELL_W-1:0]    r_cells_m1, w_cells_m1_nxt, r_cell, w_cell_nxt;
   logic [LINE_W-1:0]    r_wlines_m1, w_wlines_m1_nxt, r_xlines_m1, w_xlines_m1_nxt;
   logic [LINE_W-1:0]    r_wline, w_wline_nxt, r_xline, w_xline_nxt;
   logic [DRAIN_W-1:0]   r_drain, w_drain_nxt;
   logic [PAGE_BITS-1:0] r_w_rd_page, w_w_rd_page_nxt, r_x_rd_page, w_x_rd_page_nxt;
   logic [PAGE_BITS-1:0] r_y_page, w_y_page_nxt;
   logic [PAGE_BITS-1:0] r_w_wr_page, w_w_wr_page_nxt, r_x_wr_page, w_x_wr_page_nxt;
   logic [ARRAY_N-1:0]   r_w_we, w_w_we_nxt, r_x_we, w_x_we_nxt, r_y_valid;
   logic                 r_err, w_err_nxt;
   logic [DATA_W-1:0]    r_wr_data;

   logic [3:0]           w_opcode, w_f1, w_f2, w_f3;
   logic                 w_mul_ok, w_row_ok, w_last_cell, w_last_wline, w_last_xline;
   logic [ARRAY_N-1:0]   w_row_oh;
   logic                 w_run, w_unused_op;

   assign w_opcode     = i_operation[3:0];
   assign w_f1         = i_operation[7:4];
   assign w_f2         = i_operation[11:8];
   assign w_f3         = i_operation[15:12];
   // Bit 3 of each page field names the file: X pages must have it clear, W pages set.
   assign w_mul_ok     = ~w_f1[3] & w_f2[3] & ~w_f3[3];
   assign w_row_ok     = {28'd0, w_f2} < ARRAY_N;
   assign w_row_oh     = ARRAY_N'(1) << w_f2;
   assign w_last_cell  = (r_cell == r_cells_m1);
   assign w_last_wline = (r_wline == r_wlines_m1);
   assign w_last_xline = (r_xline == r_xlines_m1);
   assign w_run        = (r_state == StRun);
   assign w_unused_op  = ^i_operation;

   always_comb begin
      w_state_nxt     = r_state;
      w_cells_m1_nxt  = r_cells_m1;
      w_wlines_m1_nxt = r_wlines_m1;
      w_xlines_m1_nxt = r_xlines_m1;
      w_cell_nxt      = r_cell;
      w_wline_nxt     = r_wline;
      w_xline_nxt     = r_xline;
      w_drain_nxt     = r_drain;
      w_w_rd_page_nxt = r_w_rd_page;
      w_x_rd_page_nxt = r_x_rd_page;
      w_y_page_nxt    = r_y_page;
      w_w_wr_page_nxt = r_w_wr_page;
      w_x_wr_page_nxt = r_x_wr_page;
      w_w_we_nxt      = '0;
      w_x_we_nxt      = '0;
      w_err_nxt       = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (i_op_valid) begin
               case (w_opcode)
                  4'd0: begin
                  end
                  4'd1: begin
                     if (w_mul_ok) begin
                        w_x_rd_page_nxt = w_f1[PAGE_BITS-1:0];
                        w_w_rd_page_nxt = w_f2[PAGE_BITS-1:0];
                        w_y_page_nxt    = w_f3[PAGE_BITS-1:0];
                        w_state_nxt     = StRun;
                     end else begin
                        w_err_nxt = 1'b1;
                     end
                  end
                  4'd2: begin
                     if (!w_row_ok) begin
                        w_err_nxt = 1'b1;
                     end else if (w_f1[3]) begin
                        w_w_we_nxt      = w_row_oh;
                        w_w_wr_page_nxt = w_f1[PAGE_BITS-1:0];
                     end else begin
                        w_x_we_nxt      = w_row_oh;
                        w_x_wr_page_nxt = w_f1[PAGE_BITS-1:0];
                     end
                  end
                  4'd3: begin
                     w_cells_m1_nxt  = i_operation[4 +: CELL_W];
                     w_wlines_m1_nxt = i_operation[4 + CELL_W +: LINE_W];
                     w_xlines_m1_nxt = i_operation[4 + CELL_W + LINE_W +: LINE_W];
                  end
                  default: w_err_nxt = 1'b1;
               endcase
            end
         end
         StRun: begin
            // Nested counters: cell innermost, then W line, then X line.
            if (!w_last_cell) begin
               w_cell_nxt = r_cell + CELL_W'(1);
            end else begin
               w_cell_nxt = '0;
               if (!w_last_wline) begin
                  w_wline_nxt = r_wline + LINE_W'(1);
               end else begin
                  w_wline_nxt = '0;
                  if (!w_last_xline) begin
                     w_xline_nxt = r_xline + LINE_W'(1);
                  end else begin
                     w_xline_nxt = '0;
                     w_state_nxt = StDrain;
                  end
               end
            end
         end
         StDrain: begin
            if (r_drain == DRAIN_W'(DRAIN_LAT - 1)) begin
               w_drain_nxt = '0;
               w_state_nxt = StDone;
            end else begin
               w_drain_nxt = r_drain + DRAIN_W'(1);
            end
         end
         StDone: w_state_nxt = StIdle;
      endcase

      // Strobes and pulses are suppressed while stalled; state-like outputs are not.
      o_op_ready  = i_enable & (r_state == StIdle);
      o_busy      = w_run | (r_state == StDrain);
      o_done      = i_enable & (r_state == StDone);
      o_err       = i_enable & r_err;
      o_shift_en  = i_enable & w_run;
      o_w_switch  = o_shift_en & w_last_cell;
      o_x_switch  = o_w_switch & w_last_wline;
      o_w_rd_page = r_w_rd_page;
      o_x_rd_page = r_x_rd_page;
      o_w_wr_page = r_w_wr_page;
      o_x_wr_page = o_busy ? r_y_page : r_x_wr_page;
      o_w_we      = i_enable ? r_w_we : '0;
      o_x_we      = i_enable ? r_x_we : '0;
      o_wr_data   = r_wr_data;
      o_y_valid   = r_y_valid;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_cells_m1  <= CELL_W'(DEF_W_CELLS_M1);
         r_wlines_m1 <= LINE_W'(DEF_W_LINES_M1);
         r_xlines_m1 <= LINE_W'(DEF_X_LINES_M1);
         r_cell      <= '0;
         r_wline     <= '0;
         r_xline     <= '0;
         r_drain     <= '0;
         r_w_rd_page <= '0;
         r_x_rd_page <= '0;
         r_y_page    <= '0;
         r_w_wr_page <= '0;
         r_x_wr_page <= '0;
         r_w_we      <= '0;
         r_x_we      <= '0;
         r_err       <= 1'b0;
         r_wr_data   <= '0;
         r_y_valid   <= '0;
      end else if (i_enable) begin
         r_state     <= w_state_nxt;
         r_cells_m1  <= w_cells_m1_nxt;
         r_wlines_m1 <= w_wlines_m1_nxt;
         r_xlines_m1 <= w_xlines_m1_nxt;
         r_cell      <= w_cell_nxt;
         r_wline     <= w_wline_nxt;
         r_xline     <= w_xline_nxt;
         r_drain     <= w_drain_nxt;
         r_w_rd_page <= w_w_rd_page_nxt;
         r_x_rd_page <= w_x_rd_page_nxt;
         r_y_page    <= w_y_page_nxt;
         r_w_wr_page <= w_w_wr_page_nxt;
         r_x_wr_page <= w_x_wr_page_nxt;
         r_w_we      <= w_w_we_nxt;
         r_x_we      <= w_x_we_nxt;
         r_err       <= w_err_nxt;
         r_wr_data   <= i_in_data;
         r_y_valid   <= i_mult_valid;
      end
   end

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: directed bench for mm_sequencer.
// Expected pulse events (cycle, kind) are queued when an operation is issued and popped
// as the DUT raises the matching output. Cycle 1 is the cycle after the accepting edge.
module tb_mm_sequencer;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ARRAY_N   = 8;
   localparam int unsigned PAGE_BITS = 2;
   localparam int unsigned DRAIN_LAT = 17;

   localparam int KShift = 0, KWsw = 1, KXsw = 2, KDone = 3, KErr = 4;

   logic                 clk = 1'b0;
   logic                 reset, enable, op_valid, op_ready;
   logic [31:0]          operation;
   logic [DATA_W-1:0]    in_data, wr_data;
   logic [ARRAY_N-1:0]   mult_valid, w_we, x_we, y_valid;
   logic                 busy, done, err, shift_en, w_switch, x_switch;
   logic [PAGE_BITS-1:0] w_rd_page, x_rd_page, w_wr_page, x_wr_page;

   typedef struct {
      int          cyc;
      logic [7:0]  w_we;
      logic [7:0]  x_we;
      logic [1:0]  page;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } yv_t;

   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   int  q_ev[$];
   wr_t q_wr[$];
   yv_t q_yv[$];

   always #5 clk = ~clk;

   mm_sequencer dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_enable     (enable),
      .i_op_valid   (op_valid),
      .o_op_ready   (op_ready),
      .i_operation  (operation),
      .i_in_data    (in_data),
      .i_mult_valid (mult_valid),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err),
      .o_shift_en   (shift_en),
      .o_w_switch   (w_switch),
      .o_x_switch   (x_switch),
      .o_w_rd_page  (w_rd_page),
      .o_x_rd_page  (x_rd_page),
      .o_w_wr_page  (w_wr_page),
      .o_x_wr_page  (x_wr_page),
      .o_w_we       (w_we),
      .o_x_we       (x_we),
      .o_wr_data    (wr_data),
      .o_y_valid    (y_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [31:0] cfg_op(input int cm, input int wm, input int xm);
      return 32'd3 | (32'(cm) << 4) | (32'(wm) << 10) | (32'(xm) << 13);
   endfunction

   // Expected event stream of a multiply; cycles inside [s0,s1] are stalled, events
   // after cycle `cut` are dropped (reset mid-run).
   task automatic push_mult(input int cm, input int wm, input int xm, input int s0,
                            input int s1, input int cut, output int done_cyc);
      int t = 1;
      for (int x = 0; x <= xm; x++) begin
         for (int w = 0; w <= wm; w++) begin
            for (int c = 0; c <= cm; c++) begin
               while (t >= s0 && t <= s1) t++;
               if (t <= cut) begin
                  q_ev.push_back(t * 8 + KShift);
                  if (c == cm) q_ev.push_back(t * 8 + KWsw);
                  if (c == cm && w == wm) q_ev.push_back(t * 8 + KXsw);
               end
               t++;
            end
         end
      end
      for (int d = 0; d < int'(DRAIN_LAT); d++) begin
         while (t >= s0 && t <= s1) t++;
         t++;
      end
      while (t >= s0 && t <= s1) t++;
      if (t <= cut) q_ev.push_back(t * 8 + KDone);
      done_cyc = t;
   endtask

   task automatic pop_ev(input string tag, input int kind);
      int e = -1;
      if (q_ev.size() > 0) e = q_ev.pop_front();
      chk(tag, cyc * 8 + kind, e);
   endtask

   // Advance n cycles, sampling outputs at the falling edge of each.
   task automatic step(input int n);
      wr_t r;
      yv_t y;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (shift_en) pop_ev("shift_en cyc*8+kind", KShift);
         if (w_switch) pop_ev("w_switch cyc*8+kind", KWsw);
         if (x_switch) pop_ev("x_switch cyc*8+kind", KXsw);
         if (done)     pop_ev("done cyc*8+kind", KDone);
         if (err)      pop_ev("err cyc*8+kind", KErr);
         if (w_we != 0 || x_we != 0) begin
            if (q_wr.size() > 0) begin
               r = q_wr.pop_front();
               chk("we_cycle", cyc, r.cyc);
               chk("w_we", {24'd0, w_we}, {24'd0, r.w_we});
               chk("x_we", {24'd0, x_we}, {24'd0, r.x_we});
               chk("wr_page", {30'd0, (r.w_we != 0) ? w_wr_page : x_wr_page}, {30'd0, r.page});
               chk("wr_data", wr_data, r.data);
            end else begin
               chk("unexpected_we", {16'd0, w_we, x_we}, 32'd0);
            end
         end
         if (y_valid != 0) begin
            if (q_yv.size() > 0) begin
               y = q_yv.pop_front();
               chk("y_valid_cycle", cyc, y.cyc);
               chk("y_valid", {24'd0, y_valid}, {24'd0, y.val});
            end else begin
               chk("unexpected_y_valid", {24'd0, y_valid}, 32'd0);
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Offer an operation for one cycle; it must be accepted at the next edge.
   task automatic issue(input logic [31:0] op);
      op_valid  = 1'b1;
      operation = op;
      @(negedge clk);
      chk("op_ready_at_issue", {31'd0, op_ready}, 32'd1);
      @(posedge clk);
      #1;
      op_valid  = 1'b0;
      operation = '0;
      cyc       = 1;
   endtask

   task automatic drained();
      chk("events_left", q_ev.size(), 0);
      chk("writes_left", q_wr.size(), 0);
      chk("yvalid_left", q_yv.size(), 0);
   endtask

   task automatic idle_after(input string tag);
      chk({tag, "_op_ready"}, {31'd0, op_ready}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      drained();
   endtask

   initial begin
      int d;
      reset      = 1'b1;
      enable     = 1'b1;
      op_valid   = 1'b0;
      operation  = '0;
      in_data    = '0;
      mult_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
      chk("rst_status", {28'd0, busy, done, err, shift_en}, 32'd0);
      chk("rst_we", {16'd0, w_we, x_we}, 32'd0);
      chk("rst_y_valid", {24'd0, y_valid}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_pages", {24'd0, w_rd_page, x_rd_page, w_wr_page, x_wr_page}, 32'd0);
      enable = 1'b0;
      #1;
      chk("stall_idle_op_ready", {31'd0, op_ready}, 32'd0);
      enable = 1'b1;
      step(1);

      // Default sizes: 64 shift cycles, done at 82
      push_mult(15, 1, 1, 0, -1, 100000, d);
      chk("model_done_default", d, 82);
      issue(32'h0000_1801);
      step(3);
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("rd_pages", {30'd0, w_rd_page, x_rd_page}, 32'd0);
      chk("x_wr_page_is_y", {30'd0, x_wr_page}, 32'd1);
      step(d - 3);
      idle_after("default");

      // Config 3/1/1, with an op offered during RUN that must be ignored
      issue(cfg_op(3, 1, 1));
      push_mult(3, 1, 1, 0, -1, 100000, d);
      issue(32'h0000_1801);
      op_valid  = 1'b1;
      operation = 32'h0000_03A2;
      step(2);
      chk("op_ready_in_run", {31'd0, op_ready}, 32'd0);
      op_valid  = 1'b0;
      operation = '0;
      step(d - 2);
      idle_after("cfg311");

      // Same multiply with enable low in cycles 6..10
      push_mult(3, 1, 1, 6, 10, 100000, d);
      chk("model_done_stall", d, 39);
      issue(32'h0000_1801);
      step(5);
      enable = 1'b0;
      #1;
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_op_ready", {31'd0, op_ready}, 32'd0);
      step(5);
      enable = 1'b1;
      step(d - 10);
      idle_after("stall");

      // All-zero sizes: a single shift cycle
      issue(cfg_op(0, 0, 0));
      push_mult(0, 0, 0, 0, -1, 100000, d);
      issue(32'h0000_1801);
      step(d);
      idle_after("zero");

      // Serial writes: W page 2 row 3, X page 1 row 5, bad row 9
      in_data = 32'hDEAD_BEEF;
      q_wr.push_back('{cyc: 1, w_we: 8'h08, x_we: 8'h00, page: 2'd2, data: 32'hDEAD_BEEF});
      issue(32'h0000_03A2);
      step(2);
      in_data = 32'h1234_5678;
      q_wr.push_back('{cyc: 1, w_we: 8'h00, x_we: 8'h20, page: 2'd1, data: 32'h1234_5678});
      issue(32'h0000_0512);
      step(2);
      q_ev.push_back(1 * 8 + KErr);
      issue(32'h0000_09A2);
      step(2);
      drained();

      // Illegal multiply bank bit and illegal opcode
      q_ev.push_back(1 * 8 + KErr);
      issue(32'h0000_1881);
      step(1);
      chk("bad_mul_busy", {31'd0, busy}, 32'd0);
      step(1);
      q_ev.push_back(1 * 8 + KErr);
      issue(32'h0000_0007);
      step(2);
      chk("bad_op_busy", {31'd0, busy}, 32'd0);
      drained();

      // Reset in cycle 10 of RUN
      issue(cfg_op(3, 1, 1));
      push_mult(3, 1, 1, 0, -1, 10, d);
      issue(32'h0000_1801);
      step(9);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(1);
      idle_after("midrun_reset");

      // Sizes are back to defaults after reset
      push_mult(15, 1, 1, 0, -1, 100000, d);
      issue(32'h0000_1801);
      step(d);
      idle_after("post_reset_default");

      // mult_valid pulse reappears on y_valid one cycle later
      mult_valid = 8'hFF;
      q_yv.push_back('{cyc: cyc + 1, val: 8'hFF});
      step(1);
      mult_valid = '0;
      step(2);
      drained();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mm_sequencer.md
Name: mm_sequencer

Overview:
- Parametrised successor of the matrix-multiply controller.
- Decodes 32-bit operations and drives the W/X register-file controls and the systolic multiplier enable:
  - read/write page selects, row write strobes, shift enable, switch pulses, y write-back strobes.
- New over the previous generation:
  - runtime-configurable matrix sizes (config opcode) instead of hard-wired sizes;
  - valid/ready command handshake with busy/done;
  - illegal-operand error reporting;
  - a fixed-latency drain phase before completion.
- Pure controller; the memories and multiplier are instantiated by the parent.

Parameters:
- DATA_W, 32, width of in_data/wr_data.
- ARRAY_N, 8, multiplier array dimension and number of register-file rows.
- PAGE_BITS, 2, page index width (≤3).
- CELL_W, 6, width of the cell-per-line count.
- LINE_W, 3, width of the line counts; 4+CELL_W+2*LINE_W ≤ 32.
- DRAIN_LAT, 17, cycles from the last shift cycle to done (≥1).
- DEF_W_CELLS_M1, 15, reset value of w_cells_m1.
- DEF_W_LINES_M1, 1, reset value of w_lines_m1.
- DEF_X_LINES_M1, 1, reset value of x_lines_m1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global enable; all state holds while low.
- op_valid  in  1  operation offered.
- op_ready  out  1  operation accepted when op_valid&op_ready&enable at posedge.
- operation  in  32  operation word.
- in_data  in  DATA_W  serial write data.
- mult_valid  in  ARRAY_N  multiplier clear_out (per-row output valid).
- busy  out  1  multiply in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-operation pulse.
- shift_en  out  1  register files shift into the multiplier.
- w_switch  out  1  W line-boundary pulse.
- x_switch  out  1  X line-boundary pulse.
- w_rd_page  out  PAGE_BITS  W read page.
- x_rd_page  out  PAGE_BITS  X read page.
- w_wr_page  out  PAGE_BITS  W serial write page.
- x_wr_page  out  PAGE_BITS  X write page (serial write or y write-back).
- w_we  out  ARRAY_N  one-hot W row write strobe.
- x_we  out  ARRAY_N  one-hot X row write strobe.
- wr_data  out  DATA_W  registered in_data.
- y_valid  out  ARRAY_N  mult_valid delayed one cycle; bulk write to x_wr_page.

Behaviour:
- Decode:
  - opcode = op[3:0].
  - Page fields: bit 3 selects the file (0=X, 1=W); bits [PAGE_BITS-1:0] give the page.
  - 0: idle/no-op. Accepted, no effect.
  - 1: multiply. x page = op[7:4] (bit 3 must be 0); w page = op[11:8] (bit 3 must be 1); y page = op[15:12] (bit 3 must be 0).
  - 2: serial write. dest page = op[7:4]; row = op[11:8].
  - 3: config. w_cells_m1 = op[4+:CELL_W]; w_lines_m1 = next LINE_W bits; x_lines_m1 = next LINE_W bits.
  - 4–15: illegal.
- Reset: state IDLE, all counters 0, sizes at DEF_* values; all outputs 0 except op_ready=1.
- enable low:
  - no register changes;
  - shift_en, w_switch, x_switch, w_we, x_we, done, err are forced to 0;
  - op_ready is forced to 0.
- FSM states: IDLE, RUN, DRAIN, DONE. op_ready is high only in IDLE.
- IDLE, opcode 1 legal:
  - latch the pages;
  - go to RUN;
  - busy rises the next cycle.
- IDLE, opcode 1 with a bad bank bit, or opcode ≥4: err pulses the next cycle; stay IDLE; nothing else changes.
- IDLE, opcode 2:
  - next cycle, exactly one strobe pulses for one cycle: w_we[row] if dest bit 3 = 1, else x_we[row];
  - wr_data = in_data; the corresponding wr_page = dest page;
  - row ≥ ARRAY_N → err pulse, no write.
- IDLE, opcode 3: sizes update the next cycle and affect only subsequent multiplies.
- RUN:
  - shift_en = 1 every enabled cycle;
  - counters cell (0..w_cells_m1), wline (0..w_lines_m1), xline (0..x_lines_m1) advance in that nesting order;
  - w_switch = (cell == w_cells_m1);
  - x_switch = w_switch & (wline == w_lines_m1);
  - total RUN length N = (w_cells_m1+1)(w_lines_m1+1)(x_lines_m1+1) cycles;
  - on the final cycle (x_switch and xline == x_lines_m1), counters wrap to 0 and the FSM goes to DRAIN.
- DRAIN: count DRAIN_LAT cycles, then go to DONE.
- DONE: done=1 for one cycle, busy drops, then IDLE.
- Timing: with acceptance at edge 0, shift_en is high in cycles 1..N, done is high in cycle N+DRAIN_LAT+1, and op_ready is high from cycle N+DRAIN_LAT+2.
- y_valid <= mult_valid on every enabled cycle, in any state.
- x_wr_page equals the latched y page while busy, and the serial dest page otherwise.
- All-zero sizes: N=1, legal.
- op_valid while busy: ignored, not queued; the operation must be held by the issuer.
- Reset mid-run: returns to IDLE next cycle, no done pulse, sizes back to defaults.

Test Plan:
- Reset, then idle: op_ready=1, busy=done=err=shift_en=0; sizes default; multiply x=0, w=8, y=1 → shift_en for 64 cycles, done at cycle 64+17+1=82.
- Config cells_m1=3, w_lines_m1=1, x_lines_m1=1, then multiply → shift_en cycles 1–16; w_switch at 4, 8, 12, 16; x_switch at 8, 16; done at 34.
- Same multiply with enable low for 5 cycles at cycle 6 → outputs gated during the stall; done at cycle 39; switch pattern shifted by 5.
- Serial write op=0x0003_A2 (dest=10, row=3, data=0xDEADBEEF) → w_we=8'b0000_1000 for one cycle, w_wr_page=2, wr_data=0xDEADBEEF; a row 9 write → err pulse, no strobe.
- Multiply with x page bit 3 = 1, and opcode 7 → err pulse one cycle later, busy stays 0; op_valid during RUN → op_ready=0, no effect.
- Reset asserted at cycle 10 of RUN → IDLE next cycle, shift_en=0, no done; mult_valid=8'hFF pulse → y_valid=8'hFF exactly one cycle later.
